// File: rtl/reg_bus_sequencer.sv
// Bus-master sequencer: executes one accumulator instruction per start, moving data
// between a 16x8 register file and the accumulator over a shared tri-state bus.
module reg_bus_sequencer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] instr_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] acc_o,
    output logic       carry_o,
    output logic       zero_o,
    output logic [3:0] rf_read_addr_o,
    output logic       rf_read_en_o,
    output logic [3:0] rf_write_addr_o,
    output logic       rf_write_en_o,
    inout  wire  [7:0] bus_io
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_CLR   = 4'h7;

    state_e      state_q, state_d;
    logic [7:0]  instr_q, instr_d;
    logic [7:0]  acc_q, acc_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic [8:0]  sum, diff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            instr_q <= 8'h00;
            acc_q   <= 8'h00;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // Borrow falls out as bit 8 of the 9-bit difference.
    assign sum  = {1'b0, acc_q} + {1'b0, bus_io};
    assign diff = {1'b0, acc_q} - {1'b0, bus_io};

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    instr_d = instr_i;
                    case (instr_i[7:4])
                        OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_XOR: state_d = S_READ;
                        OP_STORE: state_d = S_WRITE;
                        OP_CLR: begin
                            acc_d   = 8'h00;
                            carry_d = 1'b0;
                            zero_d  = 1'b1;
                            state_d = S_DONE;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_READ: begin
                case (instr_q[7:4])
                    OP_LOAD: acc_d = bus_io;
                    OP_ADD:  {carry_d, acc_d} = sum;
                    OP_SUB: begin
                        acc_d   = diff[7:0];
                        carry_d = diff[8];
                    end
                    OP_AND:  acc_d = acc_q & bus_io;
                    OP_XOR:  acc_d = acc_q ^ bus_io;
                    default: acc_d = acc_q;
                endcase
                zero_d  = (acc_d == 8'h00);
                state_d = S_DONE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign err_o   = done_o && instr_q[7];
    assign acc_o   = acc_q;
    assign carry_o = carry_q;
    assign zero_o  = zero_q;

    // Enables are gated by reset so a reset landing on a WRITE cycle suppresses the write.
    assign rf_read_en_o    = (state_q == S_READ) && !rst_i;
    assign rf_read_addr_o  = (state_q == S_READ) ? instr_q[3:0] : 4'h0;
    assign rf_write_en_o   = (state_q == S_WRITE) && !rst_i;
    assign rf_write_addr_o = (state_q == S_WRITE) ? instr_q[3:0] : 4'h0;
    assign bus_io          = rf_write_en_o ? acc_q : 8'hzz;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Bench for reg_bus_sequencer: register-file model on the bus, ISA reference model
// feeding a scoreboard that is drained on every done pulse.
module tb_reg_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] instr = 8'h00;
    logic       busy, done, err, carry, zero, rd_en, wr_en;
    logic [7:0] acc;
    logic [3:0] rd_addr, wr_addr;
    wire  [7:0] bus;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic       err;
    } exp_t;
    exp_t sb[$];

    logic [7:0] rf [16];
    logic [7:0] mrf [16];
    logic [7:0] m_acc = 8'h00;
    logic       m_c = 1'b0;
    logic       m_z = 1'b0;

    int         done_cyc, rd_cnt, wr_cnt;
    logic [7:0] rd_bus, wr_bus;
    logic       overlap;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_sequencer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .instr_i(instr),
        .busy_o(busy), .done_o(done), .err_o(err), .acc_o(acc),
        .carry_o(carry), .zero_o(zero),
        .rf_read_addr_o(rd_addr), .rf_read_en_o(rd_en),
        .rf_write_addr_o(wr_addr), .rf_write_en_o(wr_en),
        .bus_io(bus)
    );

    // Register file: drives the bus on read, captures it on the edge after a write enable.
    assign bus = rd_en ? rf[rd_addr] : 8'hzz;
    always @(posedge clk) if (wr_en) rf[wr_addr] <= bus;

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: done seen with no instruction outstanding");
            end else begin
                e = sb.pop_front();
                if ({acc, carry, zero, err} !== {e.acc, e.c, e.z, e.err}) begin
                    errors++;
                    $display("FAIL sb_result: got acc=%h c=%b z=%b err=%b, exp acc=%h c=%b z=%b err=%b",
                             acc, carry, zero, err, e.acc, e.c, e.z, e.err);
                end
            end
        end
    end

    task automatic model(input logic [7:0] ins);
        logic [3:0] ri;
        logic [8:0] t;
        logic       e;
        ri = ins[3:0];
        e  = 1'b0;
        case (ins[7:4])
            4'h0: ;
            4'h1: begin m_acc = mrf[ri]; m_z = (m_acc == 0); end
            4'h2: mrf[ri] = m_acc;
            4'h3: begin t = m_acc + mrf[ri]; m_acc = t[7:0]; m_c = t[8]; m_z = (m_acc == 0); end
            4'h4: begin m_c = (m_acc < mrf[ri]); m_acc = m_acc - mrf[ri]; m_z = (m_acc == 0); end
            4'h5: begin m_acc = m_acc & mrf[ri]; m_z = (m_acc == 0); end
            4'h6: begin m_acc = m_acc ^ mrf[ri]; m_z = (m_acc == 0); end
            4'h7: begin m_acc = 8'h00; m_c = 1'b0; m_z = 1'b1; end
            default: e = 1'b1;
        endcase
        sb.push_back('{acc: m_acc, c: m_c, z: m_z, err: e});
    endtask

    // Issue one instruction from an IDLE-cycle negedge; returns at the next IDLE-cycle negedge.
    task automatic issue(input logic [7:0] ins, input int hold = 1);
        model(ins);
        start = 1'b1;
        instr = ins;
        @(posedge clk);
        done_cyc = -1; rd_cnt = 0; wr_cnt = 0; rd_bus = 8'h00; wr_bus = 8'h00; overlap = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            instr = ~ins;
            if (k >= hold) start = 1'b0;
            if (rd_en) begin rd_cnt++; rd_bus = bus; end
            if (wr_en) begin wr_cnt++; wr_bus = bus; if (rd_en) overlap = 1'b1; end
            if (done) begin done_cyc = k; break; end
        end
        start = 1'b0;
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: instr=%h got no done within 6 cycles", ins);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, acc, carry, zero, rd_en, wr_en, rd_addr, wr_addr} !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b err=%b acc=%h c=%b z=%b re=%b we=%b ra=%h wa=%h, exp all 0",
                     busy, done, err, acc, carry, zero, rd_en, wr_en, rd_addr, wr_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        issue(8'h70);
        checks++;
        if (done_cyc !== 1) begin errors++; $display("FAIL clr_latency: got %0d exp 1", done_cyc); end
        issue(8'h15);
        checks++;
        if (done_cyc !== 2) begin errors++; $display("FAIL load_latency: got %0d exp 2", done_cyc); end
        checks++;
        if (acc !== 8'h05 || zero !== 1'b0) begin
            errors++; $display("FAIL load_r5: got acc=%h z=%b exp 05/0", acc, zero);
        end
    endtask

    task automatic test_add();
        issue(8'h33);
        checks++;
        if (rd_cnt !== 1 || rd_bus !== 8'h03 || wr_cnt !== 0) begin
            errors++; $display("FAIL add_bus: got reads=%0d bus=%h writes=%0d exp 1/03/0", rd_cnt, rd_bus, wr_cnt);
        end
        checks++;
        if (acc !== 8'h08 || carry !== 1'b0) begin
            errors++; $display("FAIL add_r3: got acc=%h c=%b exp 08/0", acc, carry);
        end
    endtask

    task automatic test_store();
        issue(8'h2A);
        checks++;
        if (wr_cnt !== 1 || wr_bus !== 8'h08 || overlap !== 1'b0 || rd_cnt !== 0) begin
            errors++; $display("FAIL store_r10: got writes=%0d bus=%h overlap=%b reads=%0d exp 1/08/0/0",
                               wr_cnt, wr_bus, overlap, rd_cnt);
        end
        checks++;
        if (rf[10] !== 8'h08) begin errors++; $display("FAIL store_mem: got R10=%h exp 08", rf[10]); end
        issue(8'h10);
        issue(8'h1A);
        checks++;
        if (acc !== 8'h08) begin errors++; $display("FAIL load_r10: got %h exp 08", acc); end
    endtask

    task automatic test_flags();
        issue(8'h49);
        checks++;
        if (acc !== 8'hFF || carry !== 1'b1) begin errors++; $display("FAIL sub_r9: got acc=%h c=%b exp FF/1", acc, carry); end
        issue(8'h21);
        issue(8'h31);
        checks++;
        if (acc !== 8'hFE || carry !== 1'b1) begin errors++; $display("FAIL add_r1: got acc=%h c=%b exp FE/1", acc, carry); end
        issue(8'h70);
        issue(8'h18);
        issue(8'h68);
        checks++;
        if (acc !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            errors++; $display("FAIL xor_r8: got acc=%h z=%b c=%b exp 00/1/0", acc, zero, carry);
        end
    endtask

    task automatic test_illegal();
        issue(8'h15);
        issue(8'h9A);
        checks++;
        if (done_cyc !== 1 || rd_cnt !== 0 || wr_cnt !== 0) begin
            errors++; $display("FAIL illegal: got done_cyc=%0d reads=%0d writes=%0d exp 1/0/0", done_cyc, rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_start_ignored();
        int extra;
        issue(8'h14, 2);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0 || acc !== 8'h04) begin
            errors++; $display("FAIL start_ignored: got busy/done cycles=%0d acc=%h exp 0/04", extra, acc);
        end
    endtask

    task automatic test_back_to_back();
        int c0, bad;
        c0 = cyc;
        bad = 0;
        issue(8'h12); if (done_cyc !== 2) bad++;
        issue(8'h33); if (done_cyc !== 2) bad++;
        issue(8'h2C); if (done_cyc !== 2) bad++;
        checks++;
        if (cyc - c0 !== 9 || bad !== 0) begin
            errors++; $display("FAIL back_to_back: got %0d cycles, %0d late, exp 9/0", cyc - c0, bad);
        end
    endtask

    task automatic test_reset_write();
        rf[11] = 8'h55;
        mrf[11] = 8'h55;
        issue(8'h1B);
        start = 1'b1;
        instr = 8'h22;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (wr_en !== 1'b1) begin errors++; $display("FAIL rw_write_cycle: got we=%b exp 1", wr_en); end
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("FAIL rw_gate: got we=%b exp 0", wr_en); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, acc, carry, zero, rd_en, wr_en, rd_addr, wr_addr} !== 24'h0) begin
            errors++; $display("FAIL rw_reset_state: got busy=%b done=%b acc=%h c=%b z=%b re=%b we=%b, exp 0",
                               busy, done, acc, carry, zero, rd_en, wr_en);
        end
        checks++;
        if (rf[2] !== 8'h02) begin errors++; $display("FAIL rw_r2: got %h exp 02", rf[2]); end
        rst = 1'b0;
        m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0;
        issue(8'h12);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf[i]  = 8'(i);
            mrf[i] = 8'(i);
        end
        test_reset();
        @(negedge clk);
        test_load();
        test_add();
        test_store();
        test_flags();
        test_illegal();
        test_start_ignored();
        test_back_to_back();
        test_reset_write();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending exp 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
